mul256_seq_ctrl: RTL and testbench
==================================

MUL256_SEQ_CTRL -- requirements
Module: mul256_seq_ctrl

Interface
REQ-001 Parameter NW, default 4: number of 64-bit words in operand B; fixed at 4 for the 256x256 configuration.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair on a_in/b_in is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a_in  input  256  multiplicand, unsigned.
REQ-007 b_in  input  256  multiplier, unsigned.
REQ-008 mul_a  output  256  to booth_top input A.
REQ-009 mul_b  output  64  to booth_top input B.
REQ-010 mul_p  input  320  from booth_top output P: combinational, unsigned mul_a*mul_b, same cycle.
REQ-011 out_valid  output  1  prod holds a completed result.
REQ-012 out_ready  input  1  downstream accepts prod.
REQ-013 prod  output  512  unsigned a_in*b_in.

Function
REQ-014 The block SHALL compute a 256x256 unsigned product by driving booth_top once per B word and accumulating the shifted partial products.
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 in_ready SHALL equal (state==IDLE); there is no bypass from DONE to accept.
REQ-017 IDLE->RUN SHALL occur on an edge with in_valid&in_ready; on that edge a_in and b_in are registered, word counter k<=0 and accumulator acc<=0.
REQ-018 In RUN, mul_a SHALL be the registered A and mul_b SHALL be B_reg[64k+63:64k].
REQ-019 Each RUN edge SHALL update acc <= acc + (mul_p << 64k) at 512 bits with no truncation, then k <= k+1.
REQ-020 The RUN edge with k==NW-1 SHALL move to DONE; RUN SHALL last exactly NW=4 cycles.
REQ-021 Latency: accept on edge T gives out_valid=1 after edge T+4.
REQ-022 In DONE, out_valid SHALL be 1 and prod SHALL equal acc and hold stable until out_valid&out_ready.
REQ-023 DONE->IDLE SHALL occur on the edge with out_ready=1; out_valid then drops to 0 and in_ready rises to 1.
REQ-024 Outside RUN, mul_b SHALL be 0 and mul_a SHALL hold its last registered value.
REQ-025 in_valid SHALL be ignored in RUN and DONE; a_in/b_in changes there SHALL not affect the result.
REQ-026 Outside DONE, prod SHALL read 0.
REQ-027 Operand value 0 or all-ones SHALL need no special casing; the maximum product (2^256-1)^2 SHALL fit in 512 bits.

Reset
REQ-028 While rst_n=0, the block SHALL force state=IDLE, k=0, acc=0, A/B registers=0, out_valid=0, prod=0, mul_a=0, mul_b=0 and in_ready=1.
REQ-029 Reset asserted in RUN or DONE SHALL abort the operation immediately with no out_valid pulse; the next accept after release SHALL start from k=0.

Verification
REQ-030 Reset: rst_n low mid-cycle -> all outputs at REQ-028 values without a clock edge; in_ready=1 after release.
REQ-031 a_in=1, b_in=1, out_ready=1 -> out_valid high exactly 4 cycles after accept with prod=1, and mul_b sequence observed as 1,0,0,0.
REQ-032 a_in=b_in=2^256-1 -> prod = 0xFFFF...FFFE (64 hex digits) followed by 0x0000...0001 (64 hex digits).
REQ-033 a_in=0x89375212b2c2846546df998d06b97b0db1f056638484d609c0895e8112153524, b_in={4{64'h1e8dcd3d3b23f176}} -> prod matches the golden 512-bit model; random operand pairs (>=1000) also match the golden model.
REQ-034 Backpressure: out_ready held low for 3 cycles in DONE with in_valid=1 and changing a_in -> prod stable, in_ready=0, no new accept; accept resumes on the cycle after the out_ready handshake.
REQ-035 rst_n pulsed low at k=2 in RUN -> no out_valid; a fresh operand pair accepted after release yields a correct prod 4 cycles after accept.

Source files
------------

// File: rtl/mul256_seq_ctrl.sv
// Sequential 256x256 unsigned multiplier controller: drives an external 256x64
// combinational multiplier once per 64-bit word of B and accumulates shifted partials.
module mul256_seq_ctrl #(
    parameter int NW = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [255:0]           a_in,
    input  logic [64*NW-1:0]       b_in,
    output logic [255:0]           mul_a,
    output logic [63:0]            mul_b,
    input  logic [319:0]           mul_p,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [256+64*NW-1:0]   prod
);

    localparam int BW = 64 * NW;
    localparam int PW = 256 + BW;
    localparam int KW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   k_d;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   acc_d;
    logic [255:0]    a_q;
    logic [BW-1:0]   b_q;
    logic [63:0]     mul_b_q;
    logic [63:0]     mul_b_d;
    logic [PW-1:0]   prod_q;
    logic            out_valid_q;
    logic            in_ready_q;

    // Next word index, shifted-partial accumulation and the B word for the next RUN cycle
    always_comb begin
        k_d     = k_q + {{(KW-1){1'b0}}, 1'b1};
        acc_d   = acc_q + ({{(PW-320){1'b0}}, mul_p} << {k_q, 6'd0});
        mul_b_d = b_q[{k_d, 6'd0} +: 64];
    end

    // Control FSM with all datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mul_b_q     <= 64'd0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a_in;
                        b_q        <= b_in;
                        k_q        <= '0;
                        acc_q      <= '0;
                        mul_b_q    <= b_in[63:0];
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    k_q   <= k_d;
                    // Last word: the freshly summed value becomes the visible product
                    if (k_q == KW'(NW - 1)) begin
                        mul_b_q     <= 64'd0;
                        prod_q      <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        mul_b_q <= mul_b_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        prod_q      <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    mul_b_q     <= 64'd0;
                    prod_q      <= '0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign prod      = prod_q;
    assign mul_a     = a_q;
    assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_mul256_seq_ctrl.sv
// Randomized self-checking bench for mul256_seq_ctrl; the booth_top multiplier is
// modelled as a plain product and results are compared with a full-width reference.
module tb_mul256_seq_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] a_in;
    logic [255:0] b_in;
    logic [255:0] mul_a;
    logic [63:0]  mul_b;
    logic [319:0] mul_p;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] prod;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign mul_p = {64'd0, mul_a} * {256'd0, mul_b};

    mul256_seq_ctrl #(.NW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // One transaction: accept, four RUN cycles, optional DONE stall, handshake.
    // abort_k >= 0 pulses reset in RUN while k == abort_k instead of finishing.
    task automatic do_op(input logic [255:0] a, input logic [255:0] b,
                         input int stall, input int abort_k);
        logic [511:0] exp;
        exp = {256'd0, a} * {256'd0, b};
        @(negedge clk);
        check("in_ready_idle", in_ready, 1'b1);
        in_valid  = 1'b1;
        a_in      = a;
        b_in      = b;
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == abort_k) begin
                rst_n = 1'b0;
                #1;
                check("abort_out_valid", out_valid, 1'b0);
                check("abort_prod", prod, 512'd0);
                check("abort_mul_a", mul_a, 256'd0);
                check("abort_mul_b", mul_b, 64'd0);
                check("abort_in_ready", in_ready, 1'b1);
                @(negedge clk);
                rst_n    = 1'b1;
                in_valid = 1'b0;
                for (int j = 0; j < 6; j++) begin
                    @(negedge clk);
                    check("post_abort_out_valid", out_valid, 1'b0);
                    check("post_abort_in_ready", in_ready, 1'b1);
                end
                return;
            end
            check("run_mul_b", mul_b, b[64*i +: 64]);
            check("run_mul_a", mul_a, a);
            check("run_out_valid", out_valid, 1'b0);
            check("run_in_ready", in_ready, 1'b0);
            check("run_prod", prod, 512'd0);
            in_valid  = 1'b1;
            a_in      = rand256();
            b_in      = rand256();
            out_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("done_out_valid", out_valid, 1'b1);
        check("done_prod", prod, exp);
        check("done_mul_b", mul_b, 64'd0);
        check("done_mul_a", mul_a, a);
        check("done_in_ready", in_ready, 1'b0);
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        a_in      = rand256();
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_prod", prod, exp);
            check("stall_in_ready", in_ready, 1'b0);
            out_ready = (s == stall - 1);
            a_in      = rand256();
        end
        @(negedge clk);
        check("hs_out_valid", out_valid, 1'b0);
        check("hs_prod", prod, 512'd0);
        check("hs_in_ready", in_ready, 1'b1);
        check("hs_mul_b", mul_b, 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [255:0] ones;
        ones      = '1;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = 256'd0;
        b_in      = 256'd0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_prod", prod, 512'd0);
        check("rst_mul_a", mul_a, 256'd0);
        check("rst_mul_b", mul_b, 64'd0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1'b1);
        check("rel_out_valid", out_valid, 1'b0);

        do_op(256'd1, 256'd1, 0, -1);
        do_op(ones, ones, 3, -1);
        do_op(256'h89375212b2c2846546df998d06b97b0db1f056638484d609c0895e8112153524,
              {4{64'h1e8dcd3d3b23f176}}, 1, -1);
        do_op(256'd0, ones, 0, -1);
        do_op(ones, 256'd0, 2, -1);
        do_op(rand256(), rand256(), 0, 2);
        do_op(rand256(), rand256(), 0, -1);
        for (int n = 0; n < 1000; n++) begin
            do_op(rand256(), rand256(), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, 3)) : -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
